// File: rtl/pinsense8.sv
// pinsense8: synchronise, debounce and edge-detect up to 8 input pins,
// latching enabled edges into W1C event flags that drive a single irq.
module pinsense8 #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 48000,
    parameter int CW        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_in,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] level,
    output logic             irq
);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
    logic [WIDTH-1:0] s1, s2, events, rise_en, fall_en, accept, clr, set;
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [CW-1:0] cnt;
        assign accept[b] = (s2[b] != level[b]) && (cnt == LAST);
        // any return to the current level restarts the count
        always_ff @(posedge clk or posedge reset)
            if (reset) cnt <= '0;
            else cnt <= (s2[b] == level[b] || accept[b]) ? '0 : cnt + 1'b1;
    end
    assign clr = (we && addr == 2'd1) ? wd : '0;
    assign set = accept & ((s2 & rise_en) | (~s2 & fall_en));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            level   <= '0;
            events  <= '0;
            rise_en <= '0;
            fall_en <= '0;
        end else begin
            s1      <= pins_in;
            s2      <= s1;
            level   <= level ^ accept;
            events  <= (events & ~clr) | set;
            rise_en <= (we && addr == 2'd2) ? wd : rise_en;
            fall_en <= (we && addr == 2'd3) ? wd : fall_en;
        end
    end
    assign rd  = addr == 2'd0 ? level : addr == 2'd1 ? events : addr == 2'd2 ? rise_en : fall_en;
    assign irq = |events;
endmodule

// File: tb/tb_pinsense8.sv
// tb_pinsense8: directed test-plan steps plus randomized traffic checked
// against a window-based reference model of the debounced pins.
module tb_pinsense8;
    localparam int DB = 4;
    logic clk = 1'b0;
    logic reset, we;
    logic [1:0] addr;
    logic [7:0] pins_in, wd, rd, level;
    logic irq;
    int checks = 0, passed = 0, fails = 0;
    logic [7:0] hist [0:DB+1];
    logic [7:0] m_level, m_ev, m_rise, m_fall;

    pinsense8 #(.WIDTH(8), .DB_CYCLES(DB), .CW(16)) dut (
        .clk(clk), .reset(reset), .pins_in(pins_in), .we(we), .addr(addr),
        .wd(wd), .rd(rd), .level(level), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= DB + 1; k++) hist[k] = 8'h00;
        m_level = 0; m_ev = 0; m_rise = 0; m_fall = 0;
    endtask

    // A pin flips once its synchronised value has differed from the level for DB straight cycles.
    task automatic model_edge();
        logic [7:0] hi, lo, acc, clr;
        for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = pins_in;
        hi = 8'hFF; lo = 8'hFF;
        for (int k = 2; k <= DB + 1; k++) begin
            hi &= hist[k];
            lo &= ~hist[k];
        end
        acc = (hi & ~m_level) | (lo & m_level);
        clr = (we && addr == 2'd1) ? wd : 8'h00;
        m_ev = (m_ev & ~clr) | (acc & ((hi & m_rise) | (lo & m_fall)));
        m_level = m_level ^ acc;
        if (we && addr == 2'd2) m_rise = wd;
        if (we && addr == 2'd3) m_fall = wd;
    endtask

    task automatic tick();
        logic [7:0] mrd;
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        @(negedge clk);
        mrd = addr == 2'd0 ? m_level : addr == 2'd1 ? m_ev : addr == 2'd2 ? m_rise : m_fall;
        chk("model_level", level, m_level);
        chk("model_irq", {7'b0, irq}, {7'b0, |m_ev});
        chk("model_rd", rd, mrd);
        we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; wd = d; we = 1'b1;
        tick();
    endtask

    initial begin
        logic [6:0] glitch;
        reset = 1'b1; we = 1'b0; addr = 2'd0; wd = 8'h00; pins_in = 8'hFF;
        model_reset();
        repeat (2) tick();
        chk("reset_level", level, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);
        chk("reset_rd", rd, 8'h00);
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("t1_level", level, c == 6 ? 8'hFF : 8'h00);
        end
        addr = 2'd1;
        #1 chk("t1_events", rd, 8'h00);
        chk("t1_irq", {7'b0, irq}, 8'h00);

        pins_in = 8'h00;
        repeat (6) tick();
        chk("t2_low", level, 8'h00);
        wr(2'd2, 8'h01);
        addr = 2'd1; pins_in = 8'h01;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("t2_level", level, c == 6 ? 8'h01 : 8'h00);
            chk("t2_events", rd, c == 6 ? 8'h01 : 8'h00);
            chk("t2_irq", {7'b0, irq}, c == 6 ? 8'h01 : 8'h00);
        end

        wr(2'd1, 8'h01);
        wr(2'd2, 8'h03);
        glitch = 7'b1110111;
        for (int c = 0; c < 15; c++) begin
            pins_in = {6'b0, c < 7 ? glitch[c] : 1'b0, 1'b1};
            tick();
            chk("t3_level", level, 8'h01);
        end
        addr = 2'd1;
        #1 chk("t3_events", rd, 8'h00);
        chk("t3_irq", {7'b0, irq}, 8'h00);

        pins_in = 8'h00;
        repeat (6) tick();
        wr(2'd2, 8'h05);
        addr = 2'd1; pins_in = 8'h05;
        repeat (6) tick();
        chk("t4_events", rd, 8'h05);
        wr(2'd1, 8'h04);
        chk("t4_w1c", rd, 8'h01);
        chk("t4_irq_on", {7'b0, irq}, 8'h01);
        wr(2'd1, 8'h01);
        chk("t4_irq_off", {7'b0, irq}, 8'h00);

        wr(2'd3, 8'h04);
        addr = 2'd1; pins_in = 8'h01;
        repeat (5) tick();
        chk("t5_pre", rd, 8'h00);
        we = 1'b1; wd = 8'h04;
        tick();
        chk("t5_collision", rd, 8'h04);
        chk("t5_level", level, 8'h01);
        chk("t5_irq", {7'b0, irq}, 8'h01);

        pins_in = 8'h00;
        repeat (2) tick();
        reset = 1'b1;
        #1 model_reset();
        chk("t6_level", level, 8'h00);
        chk("t6_irq", {7'b0, irq}, 8'h00);
        chk("t6_rd", rd, 8'h00);
        pins_in = 8'hA5;
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("t6_follow", level, c == 6 ? 8'hA5 : 8'h00);
        end
        chk("t6_events", rd, 8'h00);
        chk("t6_irq_after", {7'b0, irq}, 8'h00);

        repeat (800) begin
            if ($urandom_range(0, 5) == 0) pins_in = 8'($urandom);
            addr = 2'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                wd = 8'($urandom);
                we = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
